// File: rtl/clk_div_pkg.sv
// Shared types and default constants for the divide-by-4.5 clock monitor.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    MEAS,
    LOCKED
  } mon_state_t;

  localparam int unsigned DEF_INT_A   = 4;
  localparam int unsigned DEF_INT_B   = 5;
  localparam int unsigned DEF_LOCK_N  = 4;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/clk_div_monitor_edge_sampler.sv
// Optional synchroniser stages plus the s/s_d pair; emits a one-cycle rise pulse.
module edge_sampler #(
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  localparam int unsigned N = SYNC_STAGES + 2;

  logic [N-1:0] smp;
  logic [N-1:0] vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp <= '0;
      vld <= '0;
    end else begin
      smp <= {smp[N-2:0], din};
      vld <= {vld[N-2:0], 1'b1};
    end
  end

  // vld marks s_d as holding a real post-reset sample, so a level that is
  // already high when reset releases never looks like a rising edge.
  assign rise = smp[N-2] & ~smp[N-1] & vld[N-1];

endmodule

// File: rtl/clk_div_monitor.sv
// Measures rising-edge intervals of a /4.5 clock, checks 4/5 alternation,
// reports lock, bad intervals and timeouts.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned INT_A       = DEF_INT_A,
  parameter int unsigned INT_B       = DEF_INT_B,
  parameter int unsigned LOCK_N      = DEF_LOCK_N,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned CW          = 8,
  parameter int unsigned EW          = 8,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          div_in,
  output logic [CW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          err,
  output logic [EW-1:0] err_count
);

  localparam int unsigned GW = $clog2(LOCK_N + 1);

  mon_state_t    state, state_nx;
  logic          rise;
  logic [CW-1:0] cnt, interval, expect_iv;
  logic          have_expect;
  logic [GW-1:0] good_cnt, good_inc;
  logic          measuring, edge_ev, good, bad, tmo;

  edge_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (div_in),
    .rise  (rise)
  );

  always_comb begin
    interval  = cnt + 1'b1;
    measuring = en && (state == MEAS || state == LOCKED);
    edge_ev   = measuring && rise;
    good      = edge_ev && (have_expect ? (interval == expect_iv)
                                        : (interval == CW'(INT_A) || interval == CW'(INT_B)));
    bad       = edge_ev && !good;
    // An edge coinciding with saturation is judged as an interval, not a timeout.
    tmo       = measuring && !rise && (cnt == CW'(TIMEOUT));
    good_inc  = (good_cnt == GW'(LOCK_N)) ? good_cnt : good_cnt + 1'b1;

    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = SEEK;
        SEEK:    if (rise) state_nx = MEAS;
        default: begin
          if (tmo)                                     state_nx = SEEK;
          else if (bad)                                state_nx = MEAS;
          else if (good && good_inc == GW'(LOCK_N))    state_nx = LOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      expect_iv    <= '0;
      have_expect  <= 1'b0;
      good_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      err          <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_nx;
      period_valid <= edge_ev;
      err          <= bad || tmo;
      if (edge_ev) period <= interval;
      if ((bad || tmo) && err_count != '1) err_count <= err_count + 1'b1;

      if (state == IDLE || rise)       cnt <= '0;
      else if (cnt != CW'(TIMEOUT))    cnt <= cnt + 1'b1;

      if (state_nx == IDLE || state_nx == SEEK || bad) good_cnt <= '0;
      else if (good)                                   good_cnt <= good_inc;

      // Every measured interval re-seeds the expectation; a bad one acts as a first interval.
      if (!measuring) begin
        have_expect <= 1'b0;
      end else if (edge_ev) begin
        have_expect <= 1'b1;
        if (interval == CW'(INT_A))      expect_iv <= CW'(INT_B);
        else if (interval == CW'(INT_B)) expect_iv <= CW'(INT_A);
        else                             have_expect <= 1'b0;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: per-cycle reference model, edge vector table and corner sequences.
module tb_clk_div_monitor;

  localparam int unsigned A      = 4;
  localparam int unsigned B      = 5;
  localparam int unsigned LOCK_N = 4;
  localparam int unsigned TMO    = 16;
  localparam int unsigned CW     = 8;
  localparam int unsigned EW     = 8;
  localparam int unsigned SYNC   = 0;
  localparam int unsigned EC_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset, en, div_in;
  logic [CW-1:0] period;
  logic          period_valid, locked, err;
  logic [EW-1:0] err_count;

  clk_div_monitor #(
    .INT_A(A), .INT_B(B), .LOCK_N(LOCK_N), .TIMEOUT(TMO),
    .CW(CW), .EW(EW), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .div_in(div_in),
    .period(period), .period_valid(period_valid), .locked(locked),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time-stamped edges, interval = difference of edge cycles.
  bit          q[$];
  int unsigned cyc = 0, last_edge = 0, expect_iv = 0, run = 0;
  int          mode = 0;  // 0 off, 1 waiting for first edge, 2 measuring
  int unsigned x_period = 0, x_ec = 0;
  bit          x_pv = 0, x_locked = 0, x_err = 0;

  int unsigned obs_pv = 0, obs_err = 0, last_per = 0;
  logic [31:0] snap;
  bit          alt = 1'b0;

  typedef struct {
    int unsigned gap;
    bit          pv;
    int unsigned per;
    bit          er;
    bit          lk;
    int unsigned ec;
  } vec_t;
  vec_t tbl [13];

  function automatic logic [31:0] pk(input logic [31:0] per, input logic pv, input logic lk,
                                     input logic er, input logic [31:0] ec);
    return (per << (EW + 3)) | (32'(pv) << (EW + 2)) | (32'(lk) << (EW + 1)) |
           (32'(er) << EW) | ec;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mode = 0; run = 0; expect_iv = 0;
    x_period = 0; x_pv = 0; x_locked = 0; x_err = 0; x_ec = 0;
  endtask

  task automatic model_step();
    bit rise, good;
    int unsigned iv;
    if (!reset) begin
      model_clear();
      return;
    end
    cyc++;
    x_pv = 0; x_err = 0;
    rise = (q.size() >= SYNC + 2) && q[q.size() - 1 - SYNC] && !q[q.size() - 2 - SYNC];
    if (!en) begin
      mode = 0; x_locked = 0; run = 0;
    end else if (mode == 0) begin
      mode = 1;
    end else if (mode == 1) begin
      if (rise) begin mode = 2; last_edge = cyc; expect_iv = 0; run = 0; end
    end else if (rise) begin
      iv = cyc - last_edge;
      last_edge = cyc;
      x_pv = 1; x_period = iv;
      good = (expect_iv == 0) ? (iv == A || iv == B) : (iv == expect_iv);
      if (good) begin
        if (run < LOCK_N) run++;
        if (run >= LOCK_N) x_locked = 1;
      end else begin
        x_err = 1; x_locked = 0; run = 0;
        if (x_ec < EC_MAX) x_ec++;
      end
      expect_iv = (iv == A) ? B : (iv == B) ? A : 0;
    end else if (cyc - last_edge == TMO + 1) begin
      x_err = 1; x_locked = 0; run = 0; mode = 1;
      if (x_ec < EC_MAX) x_ec++;
    end
    q.push_back(div_in);
    if (q.size() > 8) void'(q.pop_front());
  endtask

  task automatic step(input bit d, input bit e);
    @(negedge clk);
    model_step();
    check("cycle_outputs", pk(period, period_valid, locked, err, err_count),
          pk(x_period, x_pv, x_locked, x_err, x_ec));
    if (period_valid === 1'b1) begin obs_pv++; last_per = period; end
    if (err === 1'b1) obs_err++;
    div_in = d;
    en     = e;
  endtask

  // One rise followed by n-1 more cycles, so consecutive calls space rises n cycles apart.
  task automatic gap(input int unsigned n, input bit e);
    for (int unsigned i = 0; i < n; i++) begin
      step(i < 2, e);
      if (i == 2) snap = pk(period, period_valid, locked, err, err_count);
    end
  endtask

  task automatic ideal(input int unsigned n, input bit e);
    for (int unsigned k = 0; k < n; k++) begin
      gap(alt ? A : B, e);
      alt = ~alt;
    end
  endtask

  initial begin
    int first;
    logic [CW-1:0] held;
    logic [EW-1:0] ec0;

    tbl = '{'{5, 0, 0, 0, 0, 0}, '{4, 1, 5, 0, 0, 0}, '{5, 1, 4, 0, 0, 0},
            '{4, 1, 5, 0, 0, 0}, '{5, 1, 4, 0, 1, 0}, '{4, 1, 5, 0, 1, 0},
            '{4, 1, 4, 0, 1, 0}, '{5, 1, 4, 1, 0, 1}, '{4, 1, 5, 0, 0, 1},
            '{5, 1, 4, 0, 0, 1}, '{4, 1, 5, 0, 0, 1}, '{5, 1, 4, 0, 1, 1},
            '{5, 1, 5, 0, 1, 1}};

    reset = 1'b0; en = 1'b0; div_in = 1'b0;
    step(0, 0);
    step(0, 0);
    check("reset_state", pk(period, period_valid, locked, err, err_count), 0);
    reset = 1'b1;
    repeat (3) step(0, 1);

    foreach (tbl[k]) begin
      gap(tbl[k].gap, 1);
      check($sformatf("vec%0d", k), snap,
            pk(tbl[k].per, tbl[k].pv, tbl[k].lk, tbl[k].er, tbl[k].ec));
    end

    obs_err = 0;
    repeat (25) step(0, 1);
    check("timeout_single_err", obs_err, 1);
    check("timeout_err_count", err_count, 2);
    check("timeout_unlocked", locked, 0);

    obs_err = 0;
    ideal(6, 1);
    check("relock_after_timeout", locked, 1);
    check("relock_no_err", obs_err, 0);

    obs_err = 0;
    gap(17, 1);
    gap(4, 1);
    check("simul_single_err", obs_err, 1);
    check("simul_period", last_per, 17);
    check("simul_err_count", err_count, 3);

    ideal(6, 1);
    check("en_pre_locked", locked, 1);
    held = period; ec0 = err_count; obs_err = 0;
    step(0, 0);
    step(0, 0);
    check("en_drop_unlock", locked, 0);
    repeat (3) gap(4, 0);
    check("en_drop_no_err", obs_err, 0);
    check("en_drop_period_held", period, held);
    check("en_drop_errcnt_held", err_count, ec0);
    step(0, 1);
    step(0, 1);
    first = -1;
    for (int k = 0; k < 4; k++) begin
      obs_pv = 0;
      ideal(1, 1);
      if (first < 0 && obs_pv != 0) first = k;
    end
    check("en_first_pv_second_edge", first, 1);
    ideal(4, 1);
    check("pre_reset_locked", locked, 1);

    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", pk(period, period_valid, locked, err, err_count), 0);
    model_clear();
    div_in = 1'b1;
    step(1, 1);
    step(1, 1);
    reset = 1'b1;
    obs_pv = 0;
    repeat (10) step(1, 1);
    step(0, 1);
    step(0, 1);
    ideal(1, 1);
    check("reset_no_phantom_edge", obs_pv, 0);
    ideal(5, 1);
    check("relock_after_reset", locked, 1);

    repeat (260) gap(3, 1);
    check("errcnt_saturated", err_count, EC_MAX);
    obs_err = 0;
    repeat (3) gap(3, 1);
    check("sat_err_still_pulses", obs_err, 3);
    check("errcnt_stays_saturated", err_count, EC_MAX);

    for (int r = 0; r < 150; r++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        ideal(1, 1);
      end else if (sel == 7) begin
        gap($urandom_range(3, 20), 1);
      end else if (sel == 8) begin
        repeat ($urandom_range(1, 4)) step(0, 0);
        step(0, 1);
      end else begin
        gap(alt ? B : A, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "time limit");
  end

endmodule
